// File: rtl/pmem_arbiter_pkg.sv
// Shared types and default geometry for the instruction/data cache to
// physical-memory arbiter.
package pmem_arbiter_pkg;

    localparam int LINE_WIDTH_DEF = 256;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int LINE_OFFSET_W  = $clog2(LINE_WIDTH_DEF / 8);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_BUSY = 3'd1,
        D_BUSY = 3'd2,
        I_RESP = 3'd3,
        D_RESP = 3'd4
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter between instruction and data caches for one physical
// memory port; one line transaction in flight, request latched at grant.
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,

    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int OFFS_W = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {{(ADDR_WIDTH - OFFS_W){1'b1}}, {OFFS_W{1'b0}}};

    arb_state_e            state_q, state_d;
    grant_e                last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  d_req;

    assign d_req = dcache_read | dcache_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            we_q         <= we_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        we_d         = we_q;

        unique case (state_q)
            IDLE: begin
                // Icache wins when alone, or when contended and dcache had the last grant.
                if (icache_read && (!d_req || last_grant_q == GRANT_D)) begin
                    state_d      = I_BUSY;
                    addr_d       = icache_address;
                    we_d         = 1'b0;
                    last_grant_d = GRANT_I;
                end else if (d_req) begin
                    state_d      = D_BUSY;
                    addr_d       = dcache_address;
                    wdata_d      = dcache_wdata;
                    we_d         = dcache_write;
                    last_grant_d = GRANT_D;
                end
            end
            I_BUSY: begin
                if (pmem_resp) begin
                    rdata_d = pmem_rdata;
                    state_d = I_RESP;
                end
            end
            D_BUSY: begin
                if (pmem_resp) begin
                    rdata_d = pmem_rdata;
                    state_d = D_RESP;
                end
            end
            I_RESP, D_RESP: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    assign pmem_read    = (state_q == I_BUSY) || ((state_q == D_BUSY) && !we_q);
    assign pmem_write   = (state_q == D_BUSY) && we_q;
    assign pmem_address = addr_q & LINE_MASK;
    assign pmem_wdata   = wdata_q;

    assign icache_resp  = (state_q == I_RESP);
    assign dcache_resp  = (state_q == D_RESP);
    assign icache_rdata = rdata_q;
    assign dcache_rdata = rdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: cache agents push expected lines, a
// memory responder serves pmem requests, a monitor pops and compares.
`timescale 1ns/1ps
module tb_pmem_arbiter;
    import pmem_arbiter_pkg::*;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          icache_read = 1'b0;
    logic [AW-1:0] icache_address = '0;
    logic [LW-1:0] icache_rdata;
    logic          icache_resp;
    logic          dcache_read = 1'b0;
    logic          dcache_write = 1'b0;
    logic [AW-1:0] dcache_address = '0;
    logic [LW-1:0] dcache_wdata = '0;
    logic [LW-1:0] dcache_rdata;
    logic          dcache_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; logic [LW-1:0] line; } d_exp_t;
    typedef struct { logic [AW-1:0] addr; logic [LW-1:0] data; } w_exp_t;

    logic [LW-1:0] iq[$];
    d_exp_t        dq[$];
    w_exp_t        wq[$];
    int            gq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int presp_cyc = -10;
    int lat = 4;
    bit rand_lat = 1'b0;
    bit mem_en = 1'b1;
    int stray_req = 0;
    int stray_done = 0;
    bit i_out = 1'b0;
    bit d_out = 1'b0;
    logic [AW-1:0] cur_i = '0;
    logic [AW-1:0] cur_d = '0;
    int i_issued = 0, i_done = 0, d_issued = 0, d_done = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~32'h1F;
    endfunction

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        logic [31:0] w;
        w = align(a) ^ 32'hA5A5_A5A5;
        return {8{w}};
    endfunction

    // Memory responder: serves each pmem request after a latency, checks it on the way
    bit            in_txn = 1'b0;
    int            wait_n = 0;
    int            cur_lat = 1;
    int            owner = 0;
    bit            moved = 1'b0;
    logic [AW-1:0] t_addr = '0;
    logic [LW-1:0] t_wd = '0;
    logic          t_wr = 1'b0;

    always @(negedge clk) begin
        w_exp_t w;
        if (pmem_resp) begin
            pmem_resp  = 1'b0;
            pmem_rdata = {8{32'hDEAD_0000}};
        end else if (stray_req != stray_done) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {8{32'hBAD0_BAD0}};
            stray_done++;
        end else if (mem_en && (pmem_read || pmem_write)) begin
            if (!in_txn) begin
                in_txn  = 1'b1;
                wait_n  = 0;
                moved   = 1'b0;
                t_addr  = pmem_address;
                t_wd    = pmem_wdata;
                t_wr    = pmem_write;
                cur_lat = rand_lat ? $urandom_range(1, 4) : lat;
                if (pmem_write)          owner = 1;
                else if (i_out && !d_out) owner = 0;
                else if (d_out && !i_out) owner = 1;
                else                      owner = (pmem_address == align(cur_d)) ? 1 : 0;
                gq.push_back(owner);
                chk("pmem_req_outstanding", LW'(i_out || d_out), LW'(1'b1));
                chk("pmem_addr", LW'(pmem_address), LW'(align(owner == 1 ? cur_d : cur_i)));
                if (owner == 0) chk("pmem_i_is_read", LW'(pmem_read), LW'(1'b1));
            end else if (pmem_address != t_addr || pmem_wdata != t_wd ||
                         pmem_write != t_wr || pmem_read != !t_wr) begin
                moved = 1'b1;
            end
            wait_n++;
            if (wait_n >= cur_lat) begin
                chk("pmem_stable", LW'(moved), LW'(1'b0));
                if (t_wr) begin
                    if (wq.size() == 0) chk("pmem_write_unexpected", LW'(1'b1), LW'(1'b0));
                    else begin
                        w = wq.pop_front();
                        chk("pmem_waddr", LW'(t_addr), LW'(w.addr));
                        chk("pmem_wdata", t_wd, w.data);
                    end
                end
                pmem_resp  = 1'b1;
                pmem_rdata = line_of(t_addr);
                in_txn     = 1'b0;
            end
        end else begin
            in_txn = 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (pmem_resp && (pmem_read || pmem_write)) presp_cyc = cyc;
    end

    // Monitor: exclusivity every cycle, scoreboard pop on each cache resp
    always @(negedge clk) begin
        d_exp_t de;
        chk("pmem_excl", LW'(pmem_read && pmem_write), LW'(1'b0));
        chk("resp_excl", LW'(icache_resp && dcache_resp), LW'(1'b0));
        if (dcache_read && dcache_write)
            $display("NOTE: dcache_read and dcache_write both high at t=%0t, expecting a write", $time);
        if (icache_resp) begin
            if (iq.size() == 0) chk("i_resp_unexpected", LW'(1'b1), LW'(1'b0));
            else begin
                chk("i_rdata", icache_rdata, iq.pop_front());
                chk("i_resp_lat", LW'(cyc - presp_cyc), LW'(0));
                i_done++;
            end
        end
        if (dcache_resp) begin
            if (dq.size() == 0) chk("d_resp_unexpected", LW'(1'b1), LW'(1'b0));
            else begin
                de = dq.pop_front();
                if (!de.wr) chk("d_rdata", dcache_rdata, de.line);
                chk("d_resp_lat", LW'(cyc - presp_cyc), LW'(0));
                d_done++;
            end
        end
    end

    task automatic i_issue(input logic [AW-1:0] a);
        icache_read    = 1'b1;
        icache_address = a;
        cur_i          = a;
        i_out          = 1'b1;
        iq.push_back(line_of(a));
        i_issued++;
    endtask

    task automatic d_issue(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        dcache_read    = rd;
        dcache_write   = wr;
        dcache_address = a;
        dcache_wdata   = wd;
        cur_d          = a;
        d_out          = 1'b1;
        dq.push_back('{wr: wr, line: line_of(a)});
        if (wr) wq.push_back('{addr: align(a), data: wd});
        d_issued++;
    endtask

    task automatic i_wait();
        bit got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (icache_resp) got = 1'b1;
        end
        chk("i_wait_timeout", LW'(got), LW'(1'b1));
        icache_read = 1'b0;
        i_out       = 1'b0;
    endtask

    task automatic d_wait();
        bit got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (dcache_resp) got = 1'b1;
        end
        chk("d_wait_timeout", LW'(got), LW'(1'b1));
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        d_out        = 1'b0;
    endtask

    initial begin
        int end_cyc;
        repeat (3) @(negedge clk);
        chk("rst_pmem_read", LW'(pmem_read), LW'(1'b0));
        chk("rst_pmem_write", LW'(pmem_write), LW'(1'b0));
        chk("rst_resps", LW'({icache_resp, dcache_resp}), LW'(2'b00));
        chk("rst_addr", LW'(pmem_address), LW'(0));
        chk("rst_rdata", icache_rdata, '0);
        rst = 1'b0;
        @(negedge clk);

        // Contention after reset: icache, then dcache, then icache again
        gq.delete();
        i_issue(32'h0000_0100);
        d_issue(1'b1, 1'b0, 32'h8000_0200, '0);
        fork i_wait(); d_wait(); join
        i_issue(32'h0000_0140);
        d_issue(1'b1, 1'b0, 32'h8000_0240, '0);
        fork i_wait(); d_wait(); join
        chk("rr_grants", LW'(gq.size()), LW'(4));
        chk("rr_first", LW'(gq[0]), LW'(0));
        chk("rr_second", LW'(gq[1]), LW'(1));
        chk("rr_third", LW'(gq[2]), LW'(0));
        @(negedge clk);

        // Single icache fill, unaligned address, 4-cycle memory
        lat = 4;
        i_issue(32'h0000_0064);
        @(negedge clk);
        chk("fill_pmem_read", LW'(pmem_read), LW'(1'b1));
        chk("fill_pmem_write", LW'(pmem_write), LW'(1'b0));
        chk("fill_pmem_addr", LW'(pmem_address), LW'(32'h0000_0060));
        i_wait();
        @(negedge clk);
        chk("fill_resp_one_cycle", LW'(icache_resp), LW'(1'b0));

        // Dcache writeback
        lat = 5;
        d_issue(1'b0, 1'b1, 32'h0000_1000, {8{32'hDEAD_BEEF}});
        @(negedge clk);
        chk("wb_pmem_write", LW'(pmem_write), LW'(1'b1));
        chk("wb_pmem_read", LW'(pmem_read), LW'(1'b0));
        chk("wb_pmem_wdata", pmem_wdata, {8{32'hDEAD_BEEF}});
        d_wait();
        @(negedge clk);
        chk("wb_resp_one_cycle", LW'(dcache_resp), LW'(1'b0));

        // Read and write together are served as a write
        lat = 2;
        d_issue(1'b1, 1'b1, 32'h8000_0800, {8{32'h1234_5678}});
        @(negedge clk);
        chk("rw_pmem_write", LW'(pmem_write), LW'(1'b1));
        chk("rw_pmem_read", LW'(pmem_read), LW'(1'b0));
        d_wait();
        @(negedge clk);

        // Icache request arriving while dcache is busy waits its turn
        lat = 6;
        gq.delete();
        d_issue(1'b1, 1'b0, 32'h8000_0400, '0);
        repeat (2) @(negedge clk);
        i_issue(32'h0000_0300);
        fork i_wait(); d_wait(); join
        chk("late_grants", LW'(gq.size()), LW'(2));
        chk("late_first_d", LW'(gq[0]), LW'(1));
        chk("late_second_i", LW'(gq[1]), LW'(0));
        @(negedge clk);

        // Reset while icache transaction outstanding, then a stray pmem_resp
        mem_en = 1'b0;
        i_issue(32'h0000_0500);
        repeat (2) @(negedge clk);
        chk("abort_busy", LW'(pmem_read), LW'(1'b1));
        rst = 1'b1;
        #1;
        chk("abort_pmem_read", LW'(pmem_read), LW'(1'b0));
        chk("abort_pmem_write", LW'(pmem_write), LW'(1'b0));
        chk("abort_icache_resp", LW'(icache_resp), LW'(1'b0));
        chk("abort_addr", LW'(pmem_address), LW'(0));
        icache_read = 1'b0;
        i_out = 1'b0;
        iq.delete();
        i_issued--;
        @(negedge clk);
        rst = 1'b0;
        stray_req++;
        repeat (4) begin
            @(negedge clk);
            chk("stray_no_pmem", LW'(pmem_read || pmem_write), LW'(1'b0));
            chk("stray_no_resp", LW'(icache_resp || dcache_resp), LW'(1'b0));
        end
        chk("stray_rdata", icache_rdata, '0);
        mem_en = 1'b1;

        // Random back-to-back traffic from both caches
        rand_lat = 1'b1;
        end_cyc = cyc + 1000;
        fork
            begin
                while (cyc < end_cyc) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    i_issue({1'b0, 31'($urandom)});
                    i_wait();
                end
            end
            begin
                while (cyc < end_cyc) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    d_issue(1'b1, 1'b0, 32'h8000_0000, '0);
                    dq.pop_back();
                    d_issued--;
                    begin
                        bit wr = 1'($urandom);
                        d_issue(!wr, wr, {1'b1, 31'($urandom)}, {8{$urandom}});
                    end
                    d_wait();
                end
            end
        join
        repeat (5) @(negedge clk);
        chk("rand_i_count", LW'(i_done), LW'(i_issued));
        chk("rand_d_count", LW'(d_done), LW'(d_issued));
        chk("iq_empty", LW'(iq.size()), LW'(0));
        chk("dq_empty", LW'(dq.size()), LW'(0));
        chk("wq_empty", LW'(wq.size()), LW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 256, cacheline width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, physical byte address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports icache_read  input  1  and icache_address  input  ADDR_WIDTH: instruction-cache line-fill request and address.
REQ-006 SHALL have ports icache_rdata  output  LINE_WIDTH  and icache_resp  output  1: returned line and one-cycle completion pulse.
REQ-007 SHALL have ports dcache_read  input  1, dcache_write  input  1, dcache_address  input  ADDR_WIDTH, dcache_wdata  input  LINE_WIDTH: data-cache fill/writeback request.
REQ-008 SHALL have ports dcache_rdata  output  LINE_WIDTH  and dcache_resp  output  1.
REQ-009 SHALL have ports pmem_read  output  1, pmem_write  output  1, pmem_address  output  ADDR_WIDTH, pmem_wdata  output  LINE_WIDTH: physical memory request.
REQ-010 SHALL have ports pmem_rdata  input  LINE_WIDTH  and pmem_resp  input  1.

Function
REQ-011 SHALL implement FSM states IDLE, I_BUSY, D_BUSY, I_RESP, D_RESP.
REQ-012 In IDLE with only icache_read high, SHALL latch icache_address and enter I_BUSY next edge.
REQ-013 In IDLE with only dcache_read or dcache_write high, SHALL latch dcache_address, dcache_wdata and the op, and enter D_BUSY next edge.
REQ-014 In IDLE with both caches requesting, SHALL grant the requester not granted last (round-robin via 1-bit last_grant), then update last_grant.
REQ-015 dcache_read and dcache_write both high SHALL be treated as a write; a bench assertion flags it.
REQ-016 In I_BUSY/D_BUSY, SHALL drive pmem_read/pmem_write, pmem_address and pmem_wdata solely from latched registers, stable until pmem_resp.
REQ-017 pmem_address SHALL be the latched address with bits [log2(LINE_WIDTH/8)-1:0] forced to zero.
REQ-018 On pmem_resp in I_BUSY (D_BUSY), SHALL register pmem_rdata into the read-data register and enter I_RESP (D_RESP); pmem_read/pmem_write SHALL deassert on that edge.
REQ-019 In I_RESP (D_RESP), SHALL assert icache_resp (dcache_resp) for exactly one cycle with icache_rdata (dcache_rdata) equal to the registered line, then return to IDLE.
REQ-020 Minimum grant-to-resp latency SHALL be: request seen in IDLE cycle N, pmem request cycles N+1.., resp to cache one cycle after pmem_resp.
REQ-021 SHALL never assert pmem_read and pmem_write simultaneously, nor both cache resps simultaneously.
REQ-022 Requester inputs SHALL be ignored outside IDLE; a requester whose request arrives during another transaction is served at the next IDLE.
REQ-023 pmem_resp in IDLE or *_RESP SHALL be ignored.
REQ-024 For a write, dcache_rdata content at dcache_resp SHALL be don't-care; resp timing identical to reads.
REQ-025 Both rdata outputs SHALL be driven from the single registered line; only resp strobes are per-port.

Reset
REQ-026 On rst high, SHALL immediately enter IDLE, deassert pmem_read, pmem_write, icache_resp, dcache_resp, and clear latched address, wdata and rdata to 0.
REQ-027 last_grant SHALL reset to data, so the first contended grant goes to icache.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no resp issued; later pmem_resp ignored.

Structure
REQ-029 Shared package SHALL hold the arbiter state enum, LINE_WIDTH/ADDR_WIDTH defaults and line offset width constant.
REQ-030 Single module, no sub-module; one FSM plus latch registers.

Verification
REQ-031 icache_read, addr 0x0000_0064, pmem_resp after 4 cycles with line 0xA5.. -> pmem_address 0x0000_0060, icache_resp one cycle with that line.
REQ-032 Both request in IDLE after reset -> icache granted first; dcache served next; third contention -> icache.
REQ-033 dcache_write addr 0x0000_1000, wdata 0xDEAD.. -> pmem_write high, pmem_wdata stable until pmem_resp, dcache_resp one cycle, pmem_read never high.
REQ-034 icache request arrives during D_BUSY -> no pmem change; served after D_RESP/IDLE.
REQ-035 rst asserted in I_BUSY -> outputs 0 same cycle, no icache_resp, stray pmem_resp ignored.
REQ-036 Random back-to-back traffic 1000 cycles -> REQ-021 assertions hold, every request gets exactly one resp.
